// File: rtl/wb_arbiter_2m1s_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m1s_pkg: state encodings and grant constants for the 2:1 arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_arbiter_2m1s_pkg;

  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'b00,
    WB_ARB_BUSY  = 2'b01,
    WB_ARB_ABORT = 2'b10
  } wb_arb_state_e;

  localparam logic WB_ARB_M0 = 1'b0;
  localparam logic WB_ARB_M1 = 1'b1;

  localparam logic                 RST_ENABLE = 1'b1;
  localparam int                   REG_BUS_W  = 32;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD  = '0;

endpackage

`default_nettype wire

// File: rtl/wb_arb_timeout.sv
// ---------------------------------------------------------------------------
// wb_arb_timeout: slave-stall counter, flags expiry on the last allowed cycle (WB_ARB_TIMEOUT_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_timeout
  import wb_arbiter_2m1s_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  assign expired_o = stall_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expired_o) begin
      cnt_d = '0;
    end else if (stall_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/wb_arbiter_2m1s.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m1s: two-master Wishbone classic round-robin arbiter, one slave.
// Optional slave-stall timeout under WB_ARB_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arbiter_2m1s
  import wb_arbiter_2m1s_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,

  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,

`ifdef WB_ARB_TIMEOUT_EN
  output logic            timeout_o,
`endif
  output logic [1:0]      gnt_o
);

  localparam logic [DW-1:0] DAT_ZERO = DW'(ZERO_WORD);

  wb_arb_state_e state_q, state_d;
  logic          gnt_sel_q, gnt_sel_d;
  logic          last_sel_q, last_sel_d;

  logic            gnt_cyc, gnt_stb, gnt_we, oth_cyc;
  logic [AW-1:0]   gnt_adr;
  logic [DW-1:0]   gnt_dat;
  logic [DW/8-1:0] gnt_sel;
  logic            busy, in_abort, idle_like, tmo_hit, active;
  logic            ret_ack;
  logic [DW-1:0]   ret_dat;

  always_comb begin
    gnt_cyc = (gnt_sel_q == WB_ARB_M1) ? m1_cyc_i : m0_cyc_i;
    gnt_stb = (gnt_sel_q == WB_ARB_M1) ? m1_stb_i : m0_stb_i;
    gnt_we  = (gnt_sel_q == WB_ARB_M1) ? m1_we_i  : m0_we_i;
    gnt_adr = (gnt_sel_q == WB_ARB_M1) ? m1_adr_i : m0_adr_i;
    gnt_dat = (gnt_sel_q == WB_ARB_M1) ? m1_dat_i : m0_dat_i;
    gnt_sel = (gnt_sel_q == WB_ARB_M1) ? m1_sel_i : m0_sel_i;
    oth_cyc = (gnt_sel_q == WB_ARB_M1) ? m0_cyc_i : m1_cyc_i;
  end

  // Outputs are forced quiet while rst is held, not just after the reset edge.
  assign busy = (state_q == WB_ARB_BUSY) && (rst != RST_ENABLE);

`ifdef WB_ARB_TIMEOUT_EN
  logic stall, tmo_clr, timeout_q;

  assign in_abort = (state_q == WB_ARB_ABORT);
  assign stall    = busy && gnt_cyc && gnt_stb && !s_ack_i;
  assign tmo_clr  = !busy || s_ack_i || !gnt_cyc;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .stall_i   (stall),
    .expired_o (tmo_hit)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      timeout_q <= 1'b0;
    end else if (tmo_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic [31:0] unused_timeout_cfg;

  assign in_abort           = 1'b0;
  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Without the timeout feature the ABORT encoding falls through to IDLE handling.
  assign idle_like = (state_q != WB_ARB_BUSY) && !in_abort;
  assign active    = (rst != RST_ENABLE) && !idle_like;
  assign gnt_o     = {active && gnt_sel_q, active && !gnt_sel_q};

  always_comb begin
    state_d    = state_q;
    gnt_sel_d  = gnt_sel_q;
    last_sel_d = last_sel_q;
    if (idle_like) begin
      state_d = WB_ARB_IDLE;
      if (m0_cyc_i && m1_cyc_i) begin
        gnt_sel_d = !last_sel_q;
        state_d   = WB_ARB_BUSY;
      end else if (m0_cyc_i) begin
        gnt_sel_d = WB_ARB_M0;
        state_d   = WB_ARB_BUSY;
      end else if (m1_cyc_i) begin
        gnt_sel_d = WB_ARB_M1;
        state_d   = WB_ARB_BUSY;
      end
    end else if (!gnt_cyc) begin
      last_sel_d = gnt_sel_q;
      if (oth_cyc) begin
        gnt_sel_d = !gnt_sel_q;
        state_d   = WB_ARB_BUSY;
      end else begin
        state_d   = WB_ARB_IDLE;
      end
    end else if (tmo_hit) begin
      state_d = WB_ARB_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= WB_ARB_IDLE;
      gnt_sel_q  <= WB_ARB_M0;
      last_sel_q <= WB_ARB_M1;
    end else begin
      state_q    <= state_d;
      gnt_sel_q  <= gnt_sel_d;
      last_sel_q <= last_sel_d;
    end
  end

  // A timeout completes the stalled access with an error-free zero-data ack.
  assign ret_ack = s_ack_i || tmo_hit;
  assign ret_dat = (gnt_we || tmo_hit) ? DAT_ZERO : s_dat_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = DAT_ZERO;
    m1_ack_o = 1'b0;
    m1_dat_o = DAT_ZERO;
    if (busy) begin
      s_cyc_o = gnt_cyc;
      s_stb_o = gnt_stb && gnt_cyc;
      s_we_o  = gnt_we;
      s_adr_o = gnt_adr;
      s_dat_o = gnt_dat;
      s_sel_o = gnt_sel;
      if (gnt_sel_q == WB_ARB_M1) begin
        m1_ack_o = ret_ack;
        m1_dat_o = ret_dat;
      end else begin
        m0_ack_o = ret_ack;
        m0_dat_o = ret_dat;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m1s.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_2m1s: directed stimulus with an ack scoreboard for wb_arbiter_2m1s
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter_2m1s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i = 0;
  logic        s_ack_i = 0;
  logic [1:0]  gnt_o;
`ifdef WB_ARB_TIMEOUT_EN
  logic        timeout_o;
`endif

  wb_arbiter_2m1s #(
    .AW (32), .DW (32), .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk), .rst (rst),
    .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we),
    .m0_adr_i (m0_adr), .m0_dat_i (m0_dat), .m0_sel_i (m0_sel),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o),
    .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we),
    .m1_adr_i (m1_adr), .m1_dat_i (m1_dat), .m1_sel_i (m1_sel),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
    .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
`ifdef WB_ARB_TIMEOUT_EN
    .timeout_o (timeout_o),
`endif
    .gnt_o (gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every ack the DUT presents must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && (m0_ack_o || m1_ack_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'({m1_ack_o, m0_ack_o}), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_route", 32'({m1_ack_o, m0_ack_o}), mon_e.m ? 32'h2 : 32'h1);
        check("ack_data", mon_e.m ? m1_dat_o : m0_dat_o, mon_e.dat);
        check("other_dat_zero", mon_e.m ? m0_dat_o : m1_dat_o, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) begin m0_cyc = 0; m0_stb = 0; end
    else begin m1_cyc = 0; m1_stb = 0; end
  endtask

  task automatic slave_ack(input logic m, input logic [31:0] rdat, input logic [31:0] expdat);
    exp_t e;
    e.m = m;
    e.dat = expdat;
    exp_q.push_back(e);
    s_ack_i = 1'b1;
    s_dat_i = rdat;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: requests and a stray slave ack must not leak through
    tick(); tick();
    drive(0, 1, 1, 0, 32'h100, 0, 4'hF);
    s_ack_i = 1'b1;
    #2;
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_ack", 32'({m1_ack_o, m0_ack_o}), 32'h0);
    s_ack_i = 1'b0;
    drop(0);
    tick();
    rst = 1'b0;

    // Single m0 read
    drive(0, 1, 1, 0, 32'h0000_0100, 0, 4'hF);
    #2 check("t1_s_cyc_pre", 32'(s_cyc_o), 32'h0);
    tick();
    #2;
    check("t1_s_cyc", 32'(s_cyc_o), 32'h1);
    check("t1_s_adr", s_adr_o, 32'h0000_0100);
    check("t1_gnt", 32'(gnt_o), 32'h1);
    tick();
    tick();
    slave_ack(0, 32'h1234_5678, 32'h1234_5678);
    tick();
    s_ack_i = 0; s_dat_i = 0;
    drop(0);
    tick();
    #2 check("t1_gnt_idle", 32'(gnt_o), 32'h0);

    // Simultaneous requests right after reset
    pulse_reset();
    drive(0, 1, 1, 0, 32'h10, 0, 4'hF);
    drive(1, 1, 1, 0, 32'h20, 0, 4'hF);
    tick();
    #2;
    check("t2_gnt_m0", 32'(gnt_o), 32'h1);
    check("t2_adr_m0", s_adr_o, 32'h10);
    slave_ack(0, 32'hA0, 32'hA0);
    tick();
    s_ack_i = 0;
    drop(0);
    #2 check("t2_s_cyc_drop", 32'(s_cyc_o), 32'h0);
    tick();
    #2;
    check("t2_gnt_m1", 32'(gnt_o), 32'h2);
    check("t2_adr_m1", s_adr_o, 32'h20);
    check("t2_s_cyc_m1", 32'(s_cyc_o), 32'h1);
    slave_ack(1, 32'hB0, 32'hB0);
    tick();
    s_ack_i = 0;
    drop(1);
    tick();

    // Round-robin with both masters requesting continuously
    drive(0, 1, 1, 0, 32'h30, 0, 4'hF);
    drive(1, 1, 1, 0, 32'h40, 0, 4'hF);
    tick();
    for (int k = 0; k < 6; k++) begin
      #2 check("rr_grant", 32'(gnt_o), (k % 2 == 1) ? 32'h2 : 32'h1);
      slave_ack(k % 2 == 1, 32'h100 + k, 32'h100 + k);
      tick();
      s_ack_i = 0;
      drop(k % 2);
      tick();
      if (k < 5) drive(k % 2, 1, 1, 0, (k % 2 == 1) ? 32'h40 : 32'h30, 0, 4'hF);
    end
    drop(0);
    tick();

    // Slave ack while idle is never forwarded
    s_ack_i = 1'b1;
    s_dat_i = 32'hFFFF_FFFF;
    #2 check("idle_ack_ignored", 32'({m1_ack_o, m0_ack_o}), 32'h0);
    tick();
    s_ack_i = 1'b0;

    // Flush: m1 granted, drops cyc without ack, pending m0 follows
    drive(0, 1, 1, 0, 32'h50, 0, 4'hF);
    drive(1, 1, 1, 0, 32'h60, 0, 4'hF);
    tick();
    #2 check("t4_gnt_m1", 32'(gnt_o), 32'h2);
    tick();
    tick();
    drop(1);
    #2 check("t4_flush_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
    tick();
    #2;
    check("t4_gnt_m0", 32'(gnt_o), 32'h1);
    check("t4_adr_m0", s_adr_o, 32'h50);
    slave_ack(0, 32'hC0, 32'hC0);
    tick();
    s_ack_i = 0;
    drop(0);
    tick();

    // Write with byte selects, then a second transfer in the same cycle
    drive(0, 1, 1, 1, 32'h200, 32'hAABB_CCDD, 4'b0011);
    tick();
    #2;
    check("t5_s_we", 32'(s_we_o), 32'h1);
    check("t5_s_sel", 32'(s_sel_o), 32'h3);
    check("t5_s_dat", s_dat_o, 32'hAABB_CCDD);
    check("t5_s_adr", s_adr_o, 32'h200);
    slave_ack(0, 32'hDEAD_BEEF, 32'h0);
    drive(1, 1, 1, 0, 32'h300, 0, 4'hF);
    tick();
    s_ack_i = 0;
    drive(0, 1, 0, 0, 32'h204, 0, 4'hF);
    #2 check("t5_stb_gap", 32'({s_cyc_o, s_stb_o}), 32'h2);
    tick();
    drive(0, 1, 1, 0, 32'h204, 0, 4'hF);
    #2 check("t5_grant_kept", 32'(gnt_o), 32'h1);
    slave_ack(0, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
    tick();
    s_ack_i = 0;
    drop(0);
    tick();
    #2 check("t5_gnt_m1", 32'(gnt_o), 32'h2);
    slave_ack(1, 32'h77, 32'h77);
    tick();
    s_ack_i = 0;
    drop(1);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: forced zero-data ack on the 8th stalled strobe cycle
    pulse_reset();
    s_dat_i = 32'h5555_5555;
    drive(0, 1, 1, 0, 32'h400, 0, 4'hF);
    tick();
    for (int i = 0; i < 6; i++) tick();
    #2 check("t6_timeout_pre", 32'(timeout_o), 32'h0);
    tick();
    begin
      exp_t e;
      e.m = 1'b0;
      e.dat = 32'h0;
      exp_q.push_back(e);
    end
    tick();
    #2;
    check("t6_timeout_set", 32'(timeout_o), 32'h1);
    check("t6_abort_cyc", 32'({s_cyc_o, s_stb_o}), 32'h0);
    check("t6_abort_gnt", 32'(gnt_o), 32'h1);
    tick();
    drop(0);
    tick();
    #2;
    check("t6_timeout_sticky", 32'(timeout_o), 32'h1);
    check("t6_idle_gnt", 32'(gnt_o), 32'h0);
    pulse_reset();
    #2 check("t6_timeout_clr", 32'(timeout_o), 32'h0);
    s_dat_i = 0;
`endif

    tick();
    tick();
    check("ack_missing", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter_2m1s.md
Name: wb_arbiter_2m1s

Overview:
- Two-master, one-slave Wishbone classic arbiter, directly downstream of the CPU's instruction-side and data-side Wishbone bus interfaces.
- Master 0 is the data bus interface; master 1 is the instruction bus interface. Both share one slave port to the memory/peripheral interconnect.
- Grants by round-robin and holds the grant for the whole cycle (while the granted master's cyc is high).
- Steers the slave's ack and read data back to the granted master only.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT_CYCLES, 256, slave-stall limit in cycles (1..65535); used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_sel_i  in  DW/8  master 0 byte selects
- m0_dat_o  out  DW  master 0 read data
- m0_ack_o  out  1  master 0 ack
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  DW/8  slave byte selects
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- gnt_o  out  2  one-hot current grant, 00 when idle (debug)

Behaviour:
- State register: IDLE, BUSY, ABORT. Also registered gnt_sel (0/1) and last_sel (last served master).
- Reset: state=IDLE, gnt_sel=0, last_sel=1 (master 0 wins the first tie), counter=0.
- Outputs during reset and in IDLE: all s_* outputs 0, m*_ack_o 0, m*_dat_o 0, gnt_o 00.
- IDLE:
  - Requests are sampled on mX_cyc_i.
  - Only one master requesting: it is granted.
  - Both requesting: grant goes to !last_sel.
  - Next state is BUSY with gnt_sel set. Latency from cyc to slave cyc is 1 cycle.
- BUSY, slave outputs:
  - s_* is a combinational copy of the granted master's cyc/stb/we/adr/dat/sel.
  - s_stb_o = m_stb & m_cyc.
- BUSY, return path:
  - mG_ack_o = s_ack_i; mG_dat_o = s_dat_i when !we, else 0.
  - Non-granted master: ack=0, dat=0, regardless of s_ack_i.
- BUSY, release:
  - Granted cyc low: last_sel <= gnt_sel.
  - If the other master's cyc is high, move directly to BUSY with gnt_sel flipped (zero idle cycle). Otherwise go to IDLE.
- Granted master drops cyc without ack (flush): the slave sees cyc/stb fall the same cycle and the grant is released as above. No ack is generated.
- Multiple transfers in one cyc (stb toggling while cyc is held): the grant is kept throughout.
- s_ack_i while IDLE or ABORT: ignored, never forwarded.
- ABORT is reachable only with the optional feature; without it the state encoding is reserved and behaves as IDLE.
- gnt_o = {state!=IDLE && gnt_sel, state!=IDLE && !gnt_sel}.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled, counting:
  - 16-bit counter counts cycles in BUSY with s_stb_o=1 and s_ack_i=0.
  - It clears on ack, on grant change and on leaving BUSY.
- Enabled, timeout:
  - When the count reaches TIMEOUT_CYCLES-1 with still no ack, the granted master gets ack=1 with dat=0 for exactly that cycle.
  - Next state is ABORT.
  - Sticky output timeout_o (1 bit, reset 0, cleared only by rst) is set.
- Enabled, ABORT:
  - s_cyc_o and s_stb_o are forced 0, acks are 0.
  - The block waits for the granted cyc to go low, then applies the BUSY release rule.
- Disabled: no counter, no timeout_o port; BUSY waits indefinitely.

Decomposition:
- Shared defines include file holds:
  - state encodings WB_ARB_IDLE=2'b00, WB_ARB_BUSY=2'b01, WB_ARB_ABORT=2'b10;
  - grant constants WB_ARB_M0=1'b0, WB_ARB_M1=1'b1.
  - The existing RstEnable, ZeroWord and RegBus defines are reused.
- One natural sub-module, wb_arb_timeout: counter plus compare, instantiated only under WB_ARB_TIMEOUT_EN.
- Steering muxes stay in the top module.

Test Plan:
- Single m0 read:
  - Stimulus: m0 cyc/stb=1, adr=0x0000_0100, we=0; slave acks 2 cycles later with 0x1234_5678.
  - Response: s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o=1 with m0_dat_o=0x1234_5678; m1_ack_o stays 0; gnt_o=01 then 00.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 raise cyc the same cycle.
  - Response: m0 granted first; on m0 cyc drop, m1 granted next cycle with no IDLE gap; s_adr_o switches from m0's 0x10 to m1's 0x20.
- Round-robin fairness:
  - Stimulus: both masters request continuously for 6 transfers.
  - Response: grant order is m0,m1,m0,m1,m0,m1.
- Flush mid-cycle:
  - Stimulus: m1 granted; slave withholds ack; m1 drops cyc after 3 cycles.
  - Response: s_cyc_o/s_stb_o fall the same cycle; no ack to m1; pending m0 granted next cycle.
- Write with byte selects:
  - Stimulus: m0 we=1, sel=4'b0011, dat=0xAABB_CCDD.
  - Response: s_* matches exactly; m0_dat_o=0 on ack.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: slave never acks.
  - Response: m0_ack_o pulses on the 8th stb cycle with dat=0; timeout_o=1 and stays 1; s_cyc_o=0 in ABORT; rst clears timeout_o.
